serial_frame_rx: RTL
====================

# serial_frame_rx

Standalone receive end of the board-to-board serial link driven by the existing shift-register transmitter. Recovers 8-bit frames from the asynchronous `serialIn` pin using mid-bit sampling, rejects start-bit glitches, checks the stop period, and hands each byte to the Nios II parallel-out PIO through a valid/ack handshake with error status. It replaces the bit-slot-edge sampling receiver in the top level.

## Interface
Parameters:
- `BIT_CYCLES`, 16384: `CLOCK_50` cycles per bit period (8192 `clk[0]` ticks). Must be even and ≥ 4; simulation uses 16.
- `DATA_BITS`, 8: payload bits per frame.

Ports:
- `CLOCK_50`  in  1  sole clock; all logic on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `serialIn`  in  1  asynchronous line. Idle low; start bit high for one period; 8 data bits, LSB first; stop period low for one period.
- `rxData`  out  8  last accepted byte, feeding PIO `parallel_out`.
- `rxValid`  out  1  `rxData` holds an unacknowledged byte.
- `rxAck`  in  1  one-cycle consume strobe from the PIO side.
- `isReceiving`  out  1  frame in progress, from confirmed start through stop sample.
- `frameErr`  out  1  sticky: stop period sampled high.
- `overrun`  out  1  sticky: frame completed while `rxValid` was set.

## Operation
- `serialIn` passes a 2-flop synchronizer. All references below use the synchronized signal `s`.
- FSM states are IDLE, START, DATA, STOP, WAIT_LOW. A counter `cnt` of width $clog2(BIT_CYCLES) and a bit index `idx` (0..7) drive the sequencing.
- IDLE:
  - On `s`=1 after at least one cycle of `s`=0 (rising edge), go to START with `cnt`=0.
  - A line that is high out of reset does not start a frame. WAIT_LOW is used until `s`=0.
- START: at `cnt`=BIT_CYCLES/2−1, sample `s`.
  - If 1, the start bit is confirmed. Go to DATA with `cnt`=0 and `idx`=0.
  - If 0, it was a glitch. Return to IDLE with no status change.
- DATA:
  - Sample `s` whenever `cnt`=BIT_CYCLES−1 (mid-bit). Shift it into bit 7 of the shift register, moving right, so the first received bit ends in bit 0.
  - After `idx`=7, go to STOP.
- STOP: sample at `cnt`=BIT_CYCLES−1.
  - `s`=0, valid stop:
    - If `rxValid`=0, load `rxData` and set `rxValid`.
    - Otherwise keep the old `rxData` and set `overrun`.
    - Then go to IDLE.
  - `s`=1, bad stop: discard the byte, set `frameErr`, go to WAIT_LOW.
- WAIT_LOW: stay until `s`=0, then go to IDLE.
- `rxAck` with `rxValid`=1 clears `rxValid`, `frameErr` and `overrun` on the next edge.
  - `rxAck` with `rxValid`=0 clears only the sticky flags.
  - `rxAck` in the same cycle as a new load: the load wins. `rxValid` stays 1 with the new byte, `overrun` is not set, and the sticky flags clear.
- `isReceiving` = 1 in DATA and STOP, and in START after confirmation. It is combinational from the state.

## Timing
- Reset values:
  - `rxData`=0, `rxValid`=0, `isReceiving`=0, `frameErr`=0, `overrun`=0.
  - State IDLE; both synchronizer flops 0.
- Reset asserted mid-frame aborts the frame on the next edge. Nothing is loaded.
- Let t = first cycle with `s`=1, which is 2 cycles after the pin rises. Sample k (k=0 start, 1..8 data, 9 stop) occurs at t + BIT_CYCLES/2 + k·BIT_CYCLES.
- `rxValid` rises at t + 9.5·BIT_CYCLES + 1.
- Tolerates about ±5% transmitter rate error. Sampling never re-aligns within a frame.
- A next start edge is recognised no earlier than the cycle after return to IDLE.

## Structure
- Shared package `serial_link_pkg` holds:
  - state enum `rx_state_t`
  - `DATA_BITS`
  - default `BIT_CYCLES`
  - the line-polarity constants `LINE_IDLE`=0 and `START_LEVEL`=1, shared with the transmitter.
- One sub-module, `bit_sync`: parameterised 2-flop synchronizer with reset value 0.

## Test plan
All scenarios use BIT_CYCLES=16.
- Clean frame 0xA5: `rxValid` rises at t+153 with `rxData`=0xA5 and `isReceiving` high through the stop sample. `rxAck` then clears `rxValid`.
- Glitch: line high for 5 cycles, then low. No `rxValid`, flags stay 0, state returns to IDLE by t+8.
- Framing error: frame 0x3C with the line held high through the stop period. `frameErr`=1 and `rxValid`=0. A second frame 0x3C sent after the line goes low is received, and `rxAck` clears `frameErr`.
- Overrun: frames 0x11 then 0x22 with no ack. `rxData`=0x11 and `overrun`=1. `rxAck` clears both flags.
- Back-to-back frames 0x00 then 0xFF, the second starting right after the stop period, with ack between them. Both bytes are received correctly.
- Reset pulse at sample 4 of a frame: all outputs return to 0. A following frame 0x5A is received correctly.

Source files
------------

// File: rtl/serial_frame_rx_pkg.sv
// Shared serial link definitions: receiver state encoding, frame
// geometry and line polarity common to transmitter and receiver.
package serial_link_pkg;

    localparam int DATA_BITS      = 8;
    localparam int BIT_CYCLES_DEF = 16384;

    localparam logic LINE_IDLE   = 1'b0;
    localparam logic START_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_LOW
    } rx_state_t;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Receiver-to-PIO bundle: byte, valid/ack handshake and status.
// master = receiver (drives data/status), slave = PIO (drives rxAck).
interface serial_frame_rx_if #(
    parameter int W = 8
) ();

    logic [W-1:0] rxData;
    logic         rxValid;
    logic         rxAck;
    logic         isReceiving;
    logic         frameErr;
    logic         overrun;

    modport master (
        output rxData,
        output rxValid,
        output isReceiving,
        output frameErr,
        output overrun,
        input  rxAck
    );

    modport slave (
        input  rxData,
        input  rxValid,
        input  isReceiving,
        input  frameErr,
        input  overrun,
        output rxAck
    );

endinterface

// File: rtl/serial_frame_rx_bit_sync.sv
// Two-flop synchronizer, synchronous active-low reset to 0.
// Ports: clk, resetN, d (async in), q (synchronized out).
module bit_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: mid-bit sampling, start glitch rejection,
// stop check, valid/ack hand-off. Ports: CLOCK_50, reset_n,
// serialIn (async line), rx (master: rxData/rxValid/rxAck/status).
module serial_frame_rx #(
    parameter int BIT_CYCLES = serial_link_pkg::BIT_CYCLES_DEF,
    parameter int DATA_BITS  = serial_link_pkg::DATA_BITS
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               serialIn,
    serial_frame_rx_if.master  rx
);

    import serial_link_pkg::*;

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shiftReg;
    logic [DATA_BITS-1:0] dataQ;
    logic                 validQ;
    logic                 frameErrQ;
    logic                 overrunQ;
    logic                 s;
    logic                 sPrev;
    logic [1:0]           warm;

    bit_sync #(
        .WIDTH (1)
    ) uSync (
        .clk    (CLOCK_50),
        .resetN (reset_n),
        .d      (serialIn),
        .q      (s)
    );

    // The synchronizer resets to 0, so its output is meaningless for
    // two cycles; sPrev is held high until then so a line that is
    // already high out of reset is not mistaken for a start edge.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shiftReg  <= '0;
            dataQ     <= '0;
            validQ    <= 1'b0;
            frameErrQ <= 1'b0;
            overrunQ  <= 1'b0;
            sPrev     <= 1'b1;
            warm      <= 2'b00;
        end else begin
            warm  <= {warm[0], 1'b1};
            sPrev <= warm[1] ? s : 1'b1;
            cnt   <= cnt + 1'b1;

            if (rx.rxAck) begin
                validQ    <= 1'b0;
                frameErrQ <= 1'b0;
                overrunQ  <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (warm[1] && s == START_LEVEL) begin
                        if (sPrev == LINE_IDLE) begin
                            state <= START;
                            cnt   <= '0;
                        end else begin
                            state <= WAIT_LOW;
                        end
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        idx <= '0;
                        if (s == START_LEVEL) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt      <= '0;
                        idx      <= idx + 1'b1;
                        shiftReg <= {s, shiftReg[DATA_BITS-1:1]};
                        if (idx == LAST_IDX) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (s == LINE_IDLE) begin
                            // An ack in this cycle frees the slot,
                            // so the new byte wins over overrun.
                            if (!validQ || rx.rxAck) begin
                                dataQ  <= shiftReg;
                                validQ <= 1'b1;
                            end else begin
                                overrunQ <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            frameErrQ <= 1'b1;
                            state     <= WAIT_LOW;
                        end
                    end
                end
                WAIT_LOW: begin
                    if (s == LINE_IDLE) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx.rxData      = dataQ;
    assign rx.rxValid     = validQ;
    assign rx.frameErr    = frameErrQ;
    assign rx.overrun     = overrunQ;
    assign rx.isReceiving = (state == DATA) || (state == STOP);

endmodule
